zap_tag_ram_sched: RTL and testbench

Scheduler and sequencer for a single-cycle-clearable tag RAM shared by two lookup requesters (instruction and data side), one fill port and one invalidate port. It arbitrates the single RAM read port round-robin, tracks lookups through the 2-cycle RAM read pipeline, performs the tag compare, and returns tagged responses with backpressure. It also sequences whole-array invalidation so that no response is corrupted mid-handshake. It sits between the TLB/cache control logic and the tag RAM instance.

---
 rtl/zap_tag_ram_sched_if.sv | 67 ++++++
 rtl/zap_tag_ram_sched.sv | 113 +++++++++++
 tb/tb_zap_tag_ram_sched.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_tag_ram_sched_if.sv
// Signal bundle between zap_tag_ram_sched (slave) and its requesters, fill/invalidate
// sources and the tag RAM; master is the environment side.
interface zap_tag_ram_sched_if #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 20,
  parameter int DATA_W = 12
);
  localparam int IW    = $clog2(DEPTH);
  localparam int RAM_W = TAG_W + DATA_W;

  logic [1:0]        i_lk_valid;
  logic [IW-1:0]     i_lk_idx0;
  logic [IW-1:0]     i_lk_idx1;
  logic [TAG_W-1:0]  i_lk_tag0;
  logic [TAG_W-1:0]  i_lk_tag1;
  logic [1:0]        o_lk_ready;

  logic              o_rsp_valid;
  logic              o_rsp_src;
  logic              o_rsp_hit;
  logic [DATA_W-1:0] o_rsp_data;
  logic              i_rsp_ready;

  logic              i_fill_valid;
  logic [IW-1:0]     i_fill_idx;
  logic [TAG_W-1:0]  i_fill_tag;
  logic [DATA_W-1:0] i_fill_data;
  logic              o_fill_ready;

  logic              i_inv_req;
  logic              o_inv_ack;

  logic              o_ram_clken;
  logic              o_ram_wen;
  logic              o_ram_inv;
  logic [IW-1:0]     o_ram_waddr;
  logic [IW-1:0]     o_ram_raddr;
  logic [RAM_W-1:0]  o_ram_wdata;
  logic [RAM_W-1:0]  i_ram_rdata_pre;
  logic              i_ram_rdav_pre;

  modport slave (
    input  i_lk_valid, i_lk_idx0, i_lk_idx1, i_lk_tag0, i_lk_tag1,
    output o_lk_ready,
    output o_rsp_valid, o_rsp_src, o_rsp_hit, o_rsp_data,
    input  i_rsp_ready,
    input  i_fill_valid, i_fill_idx, i_fill_tag, i_fill_data,
    output o_fill_ready,
    input  i_inv_req,
    output o_inv_ack,
    output o_ram_clken, o_ram_wen, o_ram_inv, o_ram_waddr, o_ram_raddr, o_ram_wdata,
    input  i_ram_rdata_pre, i_ram_rdav_pre
  );

  modport master (
    output i_lk_valid, i_lk_idx0, i_lk_idx1, i_lk_tag0, i_lk_tag1,
    input  o_lk_ready,
    input  o_rsp_valid, o_rsp_src, o_rsp_hit, o_rsp_data,
    output i_rsp_ready,
    output i_fill_valid, i_fill_idx, i_fill_tag, i_fill_data,
    input  o_fill_ready,
    output i_inv_req,
    input  o_inv_ack,
    input  o_ram_clken, o_ram_wen, o_ram_inv, o_ram_waddr, o_ram_raddr, o_ram_wdata,
    output i_ram_rdata_pre, i_ram_rdav_pre
  );
endinterface

// File: rtl/zap_tag_ram_sched.sv
// Round-robin lookup scheduler for a 2-cycle tag RAM with tag compare, response
// backpressure, concurrent fills and stall-safe whole-array invalidation.
module zap_tag_ram_sched #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 20,
  parameter int DATA_W = 12
) (
  input  logic                i_clk,
  input  logic                i_reset,
  zap_tag_ram_sched_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    INV_IDLE,
    INV_WAIT,
    INV_ACK
  } inv_state_t;

  inv_state_t       inv_state_reg, inv_state_next;
  logic             s1_valid_reg, s1_src_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s2_valid_reg, s2_src_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             rr_ptr_reg;

  logic             clken;
  logic             grant_en;
  logic             grant_any;
  logic             grant_src;
  logic             ram_inv;
  logic             inv_ack;
  logic [1:0]       lk_ready;
  logic [IW-1:0]    lk_idx [2];
  logic [TAG_W-1:0] lk_tag [2];

  assign lk_idx[0] = bus.i_lk_idx0;
  assign lk_idx[1] = bus.i_lk_idx1;
  assign lk_tag[0] = bus.i_lk_tag0;
  assign lk_tag[1] = bus.i_lk_tag1;

  // A held response freezes the RAM and both pipe stages together.
  assign clken     = !(s2_valid_reg && !bus.i_rsp_ready);
  assign grant_en  = clken && (inv_state_reg == INV_IDLE) && !bus.i_inv_req && !i_reset;
  assign grant_any = grant_en && (|bus.i_lk_valid);
  assign grant_src = (&bus.i_lk_valid) ? rr_ptr_reg : bus.i_lk_valid[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign lk_ready[gi] = grant_any && (grant_src == 1'(gi));
  end
  assign bus.o_lk_ready = lk_ready;

  assign bus.o_ram_clken = clken;
  assign bus.o_ram_raddr = lk_idx[grant_src];
  assign bus.o_fill_ready = grant_en;
  assign bus.o_ram_wen   = bus.i_fill_valid && grant_en;
  assign bus.o_ram_waddr = bus.i_fill_idx;
  assign bus.o_ram_wdata = {bus.i_fill_data, bus.i_fill_tag};
  assign bus.o_ram_inv   = ram_inv;
  assign bus.o_inv_ack   = inv_ack;

  assign bus.o_rsp_valid = s2_valid_reg;
  assign bus.o_rsp_src   = s2_src_reg;
  assign bus.o_rsp_hit   = bus.i_ram_rdav_pre && (bus.i_ram_rdata_pre[TAG_W-1:0] == s2_tag_reg);
  assign bus.o_rsp_data  = bus.i_ram_rdata_pre[TAG_W +: DATA_W];

  // The clear waits for an enabled cycle so a stalled response is never disturbed.
  always_comb begin
    inv_state_next = inv_state_reg;
    ram_inv        = 1'b0;
    inv_ack        = 1'b0;
    case (inv_state_reg)
      INV_IDLE: begin
        if (bus.i_inv_req) inv_state_next = INV_WAIT;
      end
      INV_WAIT: begin
        if (clken) begin
          ram_inv        = 1'b1;
          inv_state_next = INV_ACK;
        end
      end
      INV_ACK: begin
        inv_ack        = 1'b1;
        inv_state_next = INV_IDLE;
      end
      default: inv_state_next = INV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      inv_state_reg <= INV_IDLE;
      s1_valid_reg  <= 1'b0;
      s1_src_reg    <= 1'b0;
      s1_tag_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_src_reg    <= 1'b0;
      s2_tag_reg    <= '0;
      rr_ptr_reg    <= 1'b0;
    end else begin
      inv_state_reg <= inv_state_next;
      if (clken) begin
        s1_valid_reg <= grant_any;
        s1_src_reg   <= grant_src;
        s1_tag_reg   <= lk_tag[grant_src];
        s2_valid_reg <= s1_valid_reg;
        s2_src_reg   <= s1_src_reg;
        s2_tag_reg   <= s1_tag_reg;
      end
      if (grant_any) rr_ptr_reg <= !grant_src;
    end
  end
endmodule

// File: tb/tb_zap_tag_ram_sched.sv
// Randomized and directed bench for zap_tag_ram_sched against a queue/array reference
// model, with a behavioural forwarding tag RAM attached.
module tb_zap_tag_ram_sched;
  localparam int DEPTH  = 32;
  localparam int TAG_W  = 20;
  localparam int DATA_W = 12;
  localparam int IW     = $clog2(DEPTH);
  localparam int RAM_W  = TAG_W + DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zap_tag_ram_sched_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  zap_tag_ram_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Tag RAM: read data appears two enabled cycles after the address and reflects
  // writes/clears landing in the cycle it is read.
  logic [RAM_W-1:0] ram_mem [DEPTH];
  logic [DEPTH-1:0] ram_vld;
  logic [IW-1:0]    ram_a1, ram_a2;

  always @(posedge clk) begin
    if (rst) begin
      ram_vld <= '0;
      ram_a1  <= '0;
      ram_a2  <= '0;
    end else begin
      if (bus.o_ram_clken) begin
        ram_a1 <= bus.o_ram_raddr;
        ram_a2 <= ram_a1;
      end
      if (bus.o_ram_inv) ram_vld <= '0;
      else if (bus.o_ram_wen) begin
        ram_mem[bus.o_ram_waddr] <= bus.o_ram_wdata;
        ram_vld[bus.o_ram_waddr] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.i_ram_rdata_pre = ram_mem[ram_a2];
    bus.i_ram_rdav_pre  = ram_vld[ram_a2];
    if (bus.o_ram_wen && bus.o_ram_waddr == ram_a2) begin
      bus.i_ram_rdata_pre = bus.o_ram_wdata;
      bus.i_ram_rdav_pre  = 1'b1;
    end
    if (bus.o_ram_inv) bus.i_ram_rdav_pre = 1'b0;
  end

  // Reference model: outstanding lookups with their enabled-cycle age, and entry contents.
  typedef struct packed {
    logic             src;
    logic [IW-1:0]    idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       age;
  } lk_t;

  lk_t               q[$];
  logic [DEPTH-1:0]  m_valid;
  logic [TAG_W-1:0]  m_tag  [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  logic              m_rr, inv_pending, ack_due, in_reset;

  initial begin
    m_valid = '0; m_rr = 1'b0; inv_pending = 1'b0; ack_due = 1'b0; in_reset = 1'b0;
  end

  always @(negedge clk) begin
    logic exp_rsp, stall, g, any, gsrc, exp_inv, exp_hit;
    logic [1:0]  exp_ready;
    logic [IW-1:0] gidx;
    lk_t head;
    if (rst) begin
      if (in_reset) begin
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("rst_lk_ready", bus.o_lk_ready, 0);
        chk("rst_fill_ready", bus.o_fill_ready, 0);
        chk("rst_inv_ack", bus.o_inv_ack, 0);
        chk("rst_ram_inv", bus.o_ram_inv, 0);
        chk("rst_ram_wen", bus.o_ram_wen, 0);
        chk("rst_clken", bus.o_ram_clken, 1);
      end
      in_reset = 1'b1;
      q.delete();
      m_valid = '0; m_rr = 1'b0; inv_pending = 1'b0; ack_due = 1'b0;
    end else begin
      in_reset = 1'b0;
      exp_rsp = (q.size() > 0) && (q[0].age >= 2);
      stall   = exp_rsp && !bus.i_rsp_ready;
      g       = !stall && !inv_pending && !ack_due && !bus.i_inv_req;
      any     = g && (bus.i_lk_valid != 2'b00);
      gsrc    = (bus.i_lk_valid == 2'b11) ? m_rr : bus.i_lk_valid[1];
      gidx    = gsrc ? bus.i_lk_idx1 : bus.i_lk_idx0;
      exp_ready = any ? (gsrc ? 2'b10 : 2'b01) : 2'b00;
      exp_inv = inv_pending && !stall;

      // This cycle's clear or fill is already visible to the response being read.
      if (exp_inv) m_valid = '0;
      else if (g && bus.i_fill_valid) begin
        m_valid[bus.i_fill_idx] = 1'b1;
        m_tag[bus.i_fill_idx]   = bus.i_fill_tag;
        m_data[bus.i_fill_idx]  = bus.i_fill_data;
      end

      chk("rsp_valid", bus.o_rsp_valid, exp_rsp);
      chk("lk_ready", bus.o_lk_ready, exp_ready);
      chk("fill_ready", bus.o_fill_ready, g);
      chk("ram_wen", bus.o_ram_wen, g && bus.i_fill_valid);
      chk("ram_clken", bus.o_ram_clken, !stall);
      chk("ram_inv", bus.o_ram_inv, exp_inv);
      chk("inv_ack", bus.o_inv_ack, ack_due);
      if (any) chk("ram_raddr", bus.o_ram_raddr, gidx);
      if (exp_rsp) begin
        head    = q[0];
        exp_hit = m_valid[head.idx] && (m_tag[head.idx] == head.tag);
        chk("rsp_src", bus.o_rsp_src, head.src);
        chk("rsp_hit", bus.o_rsp_hit, exp_hit);
        if (exp_hit) chk("rsp_data", bus.o_rsp_data, m_data[head.idx]);
        if (bus.i_rsp_ready) begin
          $display("rsp src=%0d idx=%0d hit=%0d data=%03h", bus.o_rsp_src, head.idx,
                   bus.o_rsp_hit, bus.o_rsp_data);
          void'(q.pop_front());
        end
      end

      if (!stall) foreach (q[i]) q[i].age = q[i].age + 2'd1;
      if (any) begin
        q.push_back('{src: gsrc, idx: gidx,
                      tag: (gsrc ? bus.i_lk_tag1 : bus.i_lk_tag0), age: 2'd1});
        m_rr = !gsrc;
      end

      if (ack_due) ack_due = 1'b0;
      else if (inv_pending) begin
        if (!stall) begin
          inv_pending = 1'b0;
          ack_due     = 1'b1;
        end
      end else if (bus.i_inv_req) inv_pending = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_lk_valid   = 2'b00;
    bus.i_fill_valid = 1'b0;
    bus.i_inv_req    = 1'b0;
    bus.i_rsp_ready  = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_lk_idx0 = '0; bus.i_lk_idx1 = '0; bus.i_lk_tag0 = '0; bus.i_lk_tag1 = '0;
    bus.i_fill_idx = '0; bus.i_fill_tag = '0; bus.i_fill_data = '0;
    idle_inputs();
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Fill then hit on the I-side.
    bus.i_fill_valid = 1'b1; bus.i_fill_idx = 5'd5;
    bus.i_fill_tag = 20'hABCDE; bus.i_fill_data = 12'h123;
    tick();
    bus.i_fill_valid = 1'b0;
    bus.i_lk_valid = 2'b01; bus.i_lk_idx0 = 5'd5; bus.i_lk_tag0 = 20'hABCDE;
    tick();
    bus.i_lk_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("t1_valid", bus.o_rsp_valid, 1);
    chk("t1_src", bus.o_rsp_src, 0);
    chk("t1_hit", bus.o_rsp_hit, 1);
    chk("t1_data", bus.o_rsp_data, 12'h123);
    tick();

    // Same-cycle fill and D-side lookup, then a D-side tag mismatch.
    bus.i_fill_valid = 1'b1; bus.i_fill_idx = 5'd7;
    bus.i_fill_tag = 20'h07777; bus.i_fill_data = 12'h777;
    bus.i_lk_valid = 2'b10; bus.i_lk_idx1 = 5'd7; bus.i_lk_tag1 = 20'h07777;
    tick();
    bus.i_fill_valid = 1'b0;
    bus.i_lk_tag1 = 20'h12345;
    tick();
    bus.i_lk_valid = 2'b00;
    @(negedge clk);
    chk("t2_valid", bus.o_rsp_valid, 1);
    chk("t2_src", bus.o_rsp_src, 1);
    chk("t2_hit", bus.o_rsp_hit, 1);
    chk("t2_data", bus.o_rsp_data, 12'h777);
    tick();
    @(negedge clk);
    chk("t2_miss_hit", bus.o_rsp_hit, 0);
    tick(); tick();

    // Both requesters for six cycles: grants alternate starting with I-side.
    bus.i_lk_idx0 = 5'd5; bus.i_lk_tag0 = 20'hABCDE;
    bus.i_lk_idx1 = 5'd7; bus.i_lk_tag1 = 20'h07777;
    bus.i_lk_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_rr", bus.o_lk_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    bus.i_lk_valid = 2'b00;
    tick(); tick(); tick();

    // Three-cycle response stall with two lookups in flight.
    bus.i_lk_valid = 2'b11;
    tick();
    tick();
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_valid", bus.o_rsp_valid, 1);
      chk("t4_src", bus.o_rsp_src, 0);
      chk("t4_data", bus.o_rsp_data, 12'h123);
      chk("t4_lk_ready", bus.o_lk_ready, 0);
      chk("t4_clken", bus.o_ram_clken, 0);
      tick();
    end
    bus.i_rsp_ready = 1'b1;
    bus.i_lk_valid = 2'b00;
    tick(); tick(); tick();

    // Invalidate with a lookup of the filled index in flight.
    bus.i_fill_valid = 1'b1; bus.i_fill_idx = 5'd3;
    bus.i_fill_tag = 20'h33333; bus.i_fill_data = 12'h333;
    tick();
    bus.i_fill_valid = 1'b0;
    bus.i_lk_valid = 2'b01; bus.i_lk_idx0 = 5'd3; bus.i_lk_tag0 = 20'h33333;
    tick();
    bus.i_inv_req = 1'b1;
    @(negedge clk);
    chk("t5_blocked", bus.o_lk_ready, 0);
    chk("t5_fill_blk", bus.o_fill_ready, 0);
    tick();
    @(negedge clk);
    chk("t5_inv", bus.o_ram_inv, 1);
    chk("t5_inflight_hit", bus.o_rsp_hit, 0);
    tick();
    bus.i_inv_req = 1'b0;
    @(negedge clk);
    chk("t5_ack", bus.o_inv_ack, 1);
    chk("t5_ack_blk", bus.o_lk_ready, 0);
    tick();
    @(negedge clk);
    chk("t5_regrant", bus.o_lk_ready, 2'b01);
    tick();
    bus.i_lk_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("t5_after_hit", bus.o_rsp_hit, 0);
    tick(); tick();

    // Reset with a lookup and an invalidate outstanding.
    bus.i_lk_valid = 2'b01; bus.i_lk_idx0 = 5'd5; bus.i_lk_tag0 = 20'hABCDE;
    tick();
    bus.i_lk_valid = 2'b00;
    bus.i_inv_req = 1'b1;
    tick();
    rst = 1'b1;
    bus.i_inv_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_rsp_valid", bus.o_rsp_valid, 0);
    chk("t6_clken", bus.o_ram_clken, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic; invalidate is dropped in the ack cycle and never re-raised there.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.i_lk_valid   = 2'($urandom_range(0, 3));
      bus.i_lk_idx0    = IW'($urandom_range(0, 7));
      bus.i_lk_idx1    = IW'($urandom_range(0, 7));
      bus.i_lk_tag0    = 20'h100 + 20'($urandom_range(0, 1));
      bus.i_lk_tag1    = 20'h100 + 20'($urandom_range(0, 1));
      bus.i_fill_valid = ($urandom_range(0, 2) == 0);
      bus.i_fill_idx   = IW'($urandom_range(0, 7));
      bus.i_fill_tag   = 20'h100 + 20'($urandom_range(0, 1));
      bus.i_fill_data  = 12'($urandom);
      bus.i_rsp_ready  = ($urandom_range(0, 3) != 0);
      if (bus.o_inv_ack) bus.i_inv_req = 1'b0;
      else if (!bus.i_inv_req && $urandom_range(0, 49) == 0) bus.i_inv_req = 1'b1;
      tick();
    end

    idle_inputs();
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk("drained", bus.o_rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
